// File: rtl/digit_serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first.
// Operands are latched on start; result and flags are published together on the last digit edge.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one digit processed per clock, N clocks total
module digit_serial_adder_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry_r;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   low_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] dsum_ext;
    logic [WIDTH-1:0] acc_next;

    // Carry into the digit MSB is recovered from the MSB sum bit, so no DIGIT==1 special case.
    always_comb begin
        low_sum  = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
        msb_cin  = low_sum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
        dsum_ext = WIDTH'(low_sum[DIGIT-1:0]);
        acc_next = (acc >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b ^ {WIDTH{opcode}};
                        carry_r <= opcode;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> DIGIT;
                    op_b    <= op_b >> DIGIT;
                    carry_r <= low_sum[DIGIT];
                    acc     <= acc_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        sum       <= acc_next;
                        carry_out <= low_sum[DIGIT];
                        overflow  <= msb_cin ^ low_sum[DIGIT];
                        zero      <= (acc_next == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
